// File: rtl/temp_entry_ctrl_pkg.sv
// temp_entry_ctrl_pkg: entry-state encodings, digit limit and digit clamp shared by the entry controller.
package temp_entry_ctrl_pkg;
  typedef enum logic [1:0] {
    INPUT_STATE_DONE = 2'd0,
    INPUT_STATE_ONES = 2'd1,
    INPUT_STATE_TENS = 2'd2,
    INPUT_STATE_HUNS = 2'd3
  } entry_state_t;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > DIGIT_MAX) ? DIGIT_MAX : v;
  endfunction
endpackage

// File: rtl/temp_entry_ctrl_key_debounce.sv
// temp_entry_ctrl_key_debounce: key synchroniser, optional debounce (TEMP_ENTRY_DEBOUNCE_EN) and rising-edge pulse.
module temp_entry_ctrl_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_pulse
);
  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_level;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_key};
`ifdef TEMP_ENTRY_DEBOUNCE_EN
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  // the counter runs only while the synchronised key disagrees with the accepted level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync[1] == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_db  <= r_sync[1];
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  assign w_level = r_db;
`else
  logic w_unused_db;
  assign w_unused_db = DEBOUNCE_CYCLES > 0;
  assign w_level = r_sync[1];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_level;
  assign o_pulse = w_level & ~r_prev;
endmodule

// File: rtl/temp_entry_ctrl.sv
// temp_entry_ctrl: three-digit BCD temperature entry FSM with atomic commit, abort and idle timeout.
module temp_entry_ctrl
  import temp_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TIMEOUT_CYCLES  = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_enter,
  input  logic [3:0] sw_value,
  input  logic       abort,
  output logic [1:0] entry_state,
  output logic [3:0] cur_digit,
  output logic [3:0] temp_ones,
  output logic [3:0] temp_tens,
  output logic [3:0] temp_huns,
  output logic       temp_valid,
  output logic       busy,
  output logic       timeout_flag
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  entry_state_t  r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_sh_ones, r_sh_tens, r_ones, r_tens, r_huns;
  logic          r_valid, r_to_flag;
  logic          w_enter, w_busy, w_abort, w_adv, w_to;
  temp_entry_ctrl_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk(clk), .rst(rst), .i_key(key_enter), .o_pulse(w_enter)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= INPUT_STATE_DONE;
    else     r_state <= w_next;
  // abort beats enter, enter beats timeout
  always_comb begin
    w_busy  = r_state != INPUT_STATE_DONE;
    w_abort = w_busy && abort;
    w_adv   = w_enter && !w_abort;
    w_to    = w_busy && !w_abort && !w_enter && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    w_next  = (w_abort || w_to) ? INPUT_STATE_DONE :
              w_adv ? entry_state_t'(r_state + 2'd1) : r_state;
  end
  always_comb begin
    entry_state  = r_state;
    busy         = w_busy;
    cur_digit    = clamp_digit(sw_value);
    temp_ones    = r_ones;
    temp_tens    = r_tens;
    temp_huns    = r_huns;
    temp_valid   = r_valid;
    timeout_flag = r_to_flag;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tcnt    <= '0;
      r_sh_ones <= '0;
      r_sh_tens <= '0;
      r_ones    <= '0;
      r_tens    <= '0;
      r_huns    <= '0;
      r_valid   <= 1'b0;
      r_to_flag <= 1'b0;
    end else begin
      r_tcnt  <= (w_adv || w_next == INPUT_STATE_DONE) ? '0 : r_tcnt + 1'b1;
      r_valid <= w_adv && r_state == INPUT_STATE_HUNS;
      if (w_adv && r_state == INPUT_STATE_ONES) r_sh_ones <= cur_digit;
      if (w_adv && r_state == INPUT_STATE_TENS) r_sh_tens <= cur_digit;
      if (w_adv && r_state == INPUT_STATE_HUNS) begin
        r_huns <= cur_digit;
        r_ones <= r_sh_ones;
        r_tens <= r_sh_tens;
      end
      if (w_to) r_to_flag <= 1'b1;
      else if (w_adv && r_state == INPUT_STATE_DONE) r_to_flag <= 1'b0;
    end
endmodule
